// File: rtl/i2s_pkg.sv
// i2s_pkg: register map, STATUS/CTRL bit positions and the PRESCALE width
// shared by the I2S transmitter and receiver on the GPIO sub-bus.
// Also holds the serialiser state type and a STATUS word packing helper.
package i2s_pkg;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  localparam int ST_FULL_BIT     = 0;
  localparam int ST_EMPTY_BIT    = 1;
  localparam int ST_LEVEL_LSB    = 4;
  localparam int ST_LEVEL_W      = 4;
  localparam int ST_UNDERRUN_BIT = 8;
  localparam int ST_OVERFLOW_BIT = 9;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  localparam int PRESCALE_W = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_RUN  = 1'b1
  } tx_state_t;

  function automatic logic [31:0] pack_status(
    input logic                  full,
    input logic                  empty,
    input logic [ST_LEVEL_W-1:0] level,
    input logic                  underrun,
    input logic                  overflow
  );
    logic [31:0] w;
    w                              = '0;
    w[ST_FULL_BIT]                 = full;
    w[ST_EMPTY_BIT]                = empty;
    w[ST_LEVEL_LSB +: ST_LEVEL_W]  = level;
    w[ST_UNDERRUN_BIT]             = underrun;
    w[ST_OVERFLOW_BIT]             = overflow;
    return w;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: synchronous first-word-fall-through FIFO holding {L,R} frames.
// Ports:
//   clk_sys, rst_b       clock, synchronous active-low reset
//   push, wr_data        write request and frame; ignored when full unless a
//                        pop happens on the same cycle
//   pop                  read request; ignored when empty
//   rd_data              frame at the head (valid when !empty)
//   full, empty, level   occupancy
module i2s_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ahbl_i2s_tx.sv
// ahbl_i2s_tx: AHB-Lite slave that plays stereo PCM frames as a Philips-I2S
// bus master (sck/ws/sd), MSB first, left channel first.
// Ports:
//   HCLK, HRESETn        clock, synchronous active-low reset
//   HSEL..HWDATA         AHB-Lite slave inputs (HSIZE ignored, word access)
//   HREADYOUT, HRDATA    always ready; read data muxed on data-phase address
//   sck, ws, sd          I2S bit clock, word select (1 = right), serial data
//   irq                  only with I2S_TX_IRQ_EN defined
// Registers: 0x0 DATA (push), 0x4 STATUS, 0x8 CTRL, 0xC PRESCALE.
// Build option: `define I2S_TX_IRQ_EN adds CTRL.IE and the irq output.
//
// state   | meaning
// TX_IDLE | sck/ws/sd low, divider and bit counter cleared, FIFO kept
// TX_RUN  | divider running, frames shifted out on sck falling edges
module ahbl_i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PRESCALE_RST = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        sck,
  output logic        ws,
  output logic        sd
`ifdef I2S_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int BCNT_W  = $clog2(FRAME_W);
  localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(FRAME_W - 1);
  localparam logic [BCNT_W-1:0] WS_LO  = BCNT_W'(SAMPLE_W - 1);
  localparam logic [BCNT_W-1:0] WS_HI  = BCNT_W'(FRAME_W - 2);

  logic                  dp_valid;
  logic                  dp_write;
  logic [1:0]            dp_addr;
  logic                  wr_data_reg, wr_status, wr_ctrl, wr_presc;

  logic                  ctrl_en;
  logic                  ctrl_ie;
  logic [PRESCALE_W-1:0] prescale;
  logic                  underrun;
  logic                  overflow;

  logic [FRAME_W-1:0]    fifo_rd_data;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_level;

  tx_state_t             state;
  logic [PRESCALE_W-1:0] div_cnt;
  logic [BCNT_W-1:0]     bit_cnt;
  logic [BCNT_W-1:0]     bit_next;
  logic                  first_fall;
  logic [FRAME_W-1:0]    shreg;
  logic [FRAME_W-1:0]    frame_load;
  logic                  fall;
  logic                  frame_start;

  logic                  unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= HSEL & HREADY & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_data_reg = dp_valid & dp_write & (dp_addr == REG_DATA);
  assign wr_status   = dp_valid & dp_write & (dp_addr == REG_STATUS);
  assign wr_ctrl     = dp_valid & dp_write & (dp_addr == REG_CTRL);
  assign wr_presc    = dp_valid & dp_write & (dp_addr == REG_PRESCALE);

  i2s_tx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (HCLK),
    .rst_b   (HRESETn),
    .push    (wr_data_reg),
    .wr_data ({HWDATA[31 -: SAMPLE_W], HWDATA[15 -: SAMPLE_W]}),
    .pop     (frame_start),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_en  <= 1'b0;
      prescale <= PRESCALE_W'(PRESCALE_RST);
    end else begin
      if (wr_ctrl)  ctrl_en  <= HWDATA[CTRL_EN_BIT];
      if (wr_presc) prescale <= HWDATA[PRESCALE_W-1:0];
    end
  end

`ifdef I2S_TX_IRQ_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_ie <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_ie <= HWDATA[CTRL_IE_BIT];
      irq <= ctrl_ie & ((fifo_level <= LVL_W'(FIFO_DEPTH / 2)) | underrun);
    end
  end
`else
  assign ctrl_ie = 1'b0;
`endif

  // Setting wins over a software clear landing on the same cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (frame_start & fifo_empty)
        underrun <= 1'b1;
      else if (wr_status & HWDATA[ST_UNDERRUN_BIT])
        underrun <= 1'b0;
      if (wr_data_reg & fifo_full & ~frame_start)
        overflow <= 1'b1;
      else if (wr_status & HWDATA[ST_OVERFLOW_BIT])
        overflow <= 1'b0;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid & ~dp_write) begin
      case (dp_addr)
        REG_STATUS:   HRDATA = pack_status(fifo_full, fifo_empty,
                                           ST_LEVEL_W'(fifo_level),
                                           underrun, overflow);
        REG_CTRL: begin
          HRDATA[CTRL_EN_BIT] = ctrl_en;
          HRDATA[CTRL_IE_BIT] = ctrl_ie;
        end
        REG_PRESCALE: HRDATA[PRESCALE_W-1:0] = prescale;
        default:      HRDATA = '0;
      endcase
    end
  end

  // A falling sck edge is the divider terminal count while sck is high.
  assign fall        = (state == TX_RUN) & ctrl_en & (div_cnt == '0) & sck;
  assign frame_start = fall & (first_fall | (bit_cnt == B_LAST));
  assign bit_next    = frame_start ? '0 : bit_cnt + BCNT_W'(1);
  assign frame_load  = fifo_empty ? '0 : fifo_rd_data;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= TX_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      first_fall <= 1'b1;
      shreg      <= '0;
      sck        <= 1'b0;
      ws         <= 1'b0;
      sd         <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          sck        <= 1'b0;
          ws         <= 1'b0;
          sd         <= 1'b0;
          bit_cnt    <= '0;
          first_fall <= 1'b1;
          if (ctrl_en) begin
            state   <= TX_RUN;
            div_cnt <= prescale;
          end else begin
            div_cnt <= '0;
          end
        end
        TX_RUN: begin
          if (!ctrl_en) begin
            state      <= TX_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            first_fall <= 1'b1;
            sck        <= 1'b0;
            ws         <= 1'b0;
            sd         <= 1'b0;
          end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - PRESCALE_W'(1);
          end else begin
            div_cnt <= prescale;
            sck     <= ~sck;
            if (sck) begin
              first_fall <= 1'b0;
              bit_cnt    <= bit_next;
              // ws leads each channel MSB by one bit (Philips format).
              ws         <= (bit_next >= WS_LO) && (bit_next <= WS_HI);
              if (frame_start) begin
                sd    <= frame_load[FRAME_W-1];
                shreg <= {frame_load[FRAME_W-2:0], 1'b0};
              end else begin
                sd    <= shreg[FRAME_W-1];
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
module tb_ahbl_i2s_tx;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;
  localparam logic [31:0] A_PRESC  = 32'hC;
  localparam logic [31:0] WS_WORD  = 32'h0001_FFFE;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = '0;
  logic [2:0]  HSIZE   = 3'b010;
  logic        HWRITE  = 1'b0;
  logic        HREADY  = 1'b1;
  logic [31:0] HWDATA  = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        sck, ws, sd;
`ifdef I2S_TX_IRQ_EN
  logic        irq;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_q[$];

  ahbl_i2s_tx dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .sck       (sck),
    .ws        (ws),
    .sd        (sd)
`ifdef I2S_TX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
    model_q.delete();
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = addr;
    tick();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = data;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = addr;
    tick();
    data   = HRDATA;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic push_frame(input logic [31:0] data);
    ahb_write(A_DATA, data);
    if (model_q.size() < 8) model_q.push_back(data);
  endtask

  // Watches sck falling edges, pops the expected frame at each b=0 and
  // compares the assembled sd and ws words at b=31.
  task automatic check_frames(input string tag, input int nframes,
                              input int max_cycles, output int gap);
    int          idx;
    int          cyc;
    int          first_cyc;
    int          b;
    logic        prev;
    logic [31:0] sdw, wsw, expw;
    idx = 0; cyc = 0; first_cyc = 0; gap = -1;
    sdw = '0; wsw = '0; expw = '0;
    prev = sck;
    while (idx < nframes * 32 && cyc < max_cycles) begin
      tick();
      cyc++;
      if (prev && !sck) begin
        b = idx % 32;
        if (b == 0) begin
          expw = (model_q.size() != 0) ? model_q.pop_front() : 32'h0;
          sdw = '0;
          wsw = '0;
        end
        sdw[31-b] = sd;
        wsw[31-b] = ws;
        if (idx == 0) first_cyc = cyc;
        if (idx == 1) gap = cyc - first_cyc;
        if (b == 31) begin
          checks++;
          if (sdw !== expw) begin
            failures++;
            $display("FAIL %s frame%0d sd: got %h expected %h", tag, idx / 32, sdw, expw);
          end
          checks++;
          if (wsw !== WS_WORD) begin
            failures++;
            $display("FAIL %s frame%0d ws: got %h expected %h", tag, idx / 32, wsw, WS_WORD);
          end
        end
        idx++;
      end
      prev = sck;
    end
    checks++;
    if (idx < nframes * 32) begin
      failures++;
      $display("FAIL %s timeout: got %0d bits expected %0d", tag, idx, nframes * 32);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    checks++;
    if ({HREADYOUT, sck, ws, sd} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_pins: got %b expected 1000", {HREADYOUT, sck, ws, sd});
    end
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL reset_status: got %h expected 2", r); end
    ahb_read(A_PRESC, r);
    checks++;
    if (r !== 32'h3) begin failures++; $display("FAIL reset_prescale: got %h expected 3", r); end
    ahb_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h expected 0", r); end
    ahb_write(A_DATA, 32'hFFFF_FFFF);
    ahb_read(A_DATA, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL data_read: got %h expected 0", r); end
    ahb_write(A_CTRL, 32'h2);
    ahb_read(A_CTRL, r);
    checks++;
`ifdef I2S_TX_IRQ_EN
    if (r !== 32'h2) begin failures++; $display("FAIL ctrl_ie: got %h expected 2", r); end
`else
    if (r !== 32'h0) begin failures++; $display("FAIL ctrl_ie: got %h expected 0", r); end
`endif
  endtask

  task automatic test_serial_basic();
    int gap;
    do_reset();
    ahb_write(A_PRESC, 32'h0);
    push_frame(32'hA5A5_0F0F);
    ahb_write(A_CTRL, 32'h1);
    check_frames("basic", 1, 200, gap);
    checks++;
    if (gap !== 2) begin failures++; $display("FAIL basic_period: got %0d expected 2", gap); end
    ahb_write(A_CTRL, 32'h0);
  endtask

  task automatic test_underrun();
    int          gap;
    logic [31:0] r;
    do_reset();
    ahb_write(A_PRESC, 32'h0);
    ahb_write(A_CTRL, 32'h1);
    fork
      check_frames("underrun", 2, 400, gap);
      begin
        repeat (30) tick();
        push_frame(32'h1234_5678);
      end
    join
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h102) begin failures++; $display("FAIL underrun_status: got %h expected 102", r); end
    ahb_write(A_CTRL, 32'h0);
    ahb_write(A_STATUS, 32'h100);
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL underrun_clear: got %h expected 2", r); end
  endtask

  task automatic test_overflow();
    int          gap;
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 9; i++) push_frame(32'h1020_3040 + 32'(i) * 32'h0101_0101);
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h281) begin failures++; $display("FAIL overflow_status: got %h expected 281", r); end
    ahb_write(A_STATUS, 32'h200);
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h081) begin failures++; $display("FAIL overflow_clear: got %h expected 81", r); end
    ahb_write(A_PRESC, 32'h0);
    ahb_write(A_CTRL, 32'h1);
    check_frames("overflow", 8, 1200, gap);
    repeat (7) tick();
    HRESETn = 1'b0;
    tick();
    checks++;
    if ({sck, ws, sd} !== 3'b000) begin
      failures++;
      $display("FAIL midrun_reset_pins: got %b expected 000", {sck, ws, sd});
    end
    HRESETn = 1'b1;
    model_q.delete();
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL midrun_reset_status: got %h expected 2", r); end
    ahb_read(A_PRESC, r);
    checks++;
    if (r !== 32'h3) begin failures++; $display("FAIL midrun_reset_prescale: got %h expected 3", r); end
  endtask

  task automatic test_enable_abort();
    int          gap;
    int          idx;
    int          cyc;
    logic        prev;
    logic [31:0] r;
    logic [31:0] junk;
    do_reset();
    push_frame(32'hCAFE_BABE);
    push_frame(32'h8001_7FFE);
    ahb_write(A_CTRL, 32'h1);
    idx = 0; cyc = 0; prev = sck;
    while (idx <= 10 && cyc < 1000) begin
      tick();
      cyc++;
      if (prev && !sck) begin
        if (idx == 0) junk = model_q.pop_front();
        idx++;
      end
      prev = sck;
    end
    checks++;
    if (idx <= 10) begin failures++; $display("FAIL abort_wait: got %0d bits expected 11", idx); end
    ahb_write(A_CTRL, 32'h0);
    tick();
    checks++;
    if ({sck, ws, sd} !== 3'b000) begin
      failures++;
      $display("FAIL abort_pins: got %b expected 000", {sck, ws, sd});
    end
    ahb_read(A_STATUS, r);
    checks++;
    if (r !== 32'h10) begin failures++; $display("FAIL abort_status: got %h expected 10", r); end
    ahb_write(A_CTRL, 32'h1);
    check_frames("reenable", 1, 400, gap);
    checks++;
    if (gap !== 8) begin failures++; $display("FAIL reenable_period: got %0d expected 8", gap); end
    ahb_write(A_CTRL, 32'h0);
  endtask

`ifdef I2S_TX_IRQ_EN
  task automatic test_irq();
    int   cyc;
    logic prev;
    do_reset();
    for (int i = 0; i < 5; i++) push_frame(32'h0101_0101 * 32'(i + 1));
    ahb_write(A_CTRL, 32'h3);
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_level5: got %b expected 0", irq); end
    cyc = 0; prev = sck;
    while (!(prev && !sck) && cyc < 200) begin
      prev = sck;
      tick();
      cyc++;
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_pop_edge: got %b expected 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_level4: got %b expected 1", irq); end
    ahb_write(A_CTRL, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_serial_basic();
    test_underrun();
    test_overflow();
    test_enable_abort();
`ifdef I2S_TX_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
